// File: rtl/lfsr_step_ctrl_if.sv
// Request/response bundle between the button/switch front end and the
// LFSR step sequencer.
interface lfsr_step_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] seed;
  logic             load_req;
  logic             step_req;
  logic             burst_req;
  logic [7:0]       burst_len;
  logic             run_req;
  logic             stop_req;
  logic [DIV_W-1:0] div;
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_data;
  logic             lfsr_en;
  logic [1:0]       state;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output seed, load_req, step_req, burst_req, burst_len, run_req, stop_req, div,
    input  lfsr_load, lfsr_data, lfsr_en, state, busy, done, step_cnt
  );

  modport slave (
    input  seed, load_req, step_req, burst_req, burst_len, run_req, stop_req, div,
    output lfsr_load, lfsr_data, lfsr_en, state, busy, done, step_cnt
  );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// Sequencer for the 8-bit LFSR / hex-display datapath: turns single-cycle
// user requests into registered lfsr_load / lfsr_en strobes, pacing
// RUN and BURST stepping with a programmable prescaler.
module lfsr_step_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  lfsr_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t           st_q, st_n;
  logic [DIV_W-1:0] pcnt_q, pcnt_n;
  logic [7:0]       rem_q, rem_n;
  logic             load_q, load_n;
  logic             en_q, en_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             tick;

  // Prescaler tick uses div live so a lowered div takes effect at once
  assign tick = (pcnt_q >= bus.div);

  // Registered state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      pcnt_q <= '0;
      rem_q  <= '0;
      load_q <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_n;
      pcnt_q <= pcnt_n;
      rem_q  <= rem_n;
      load_q <= load_n;
      en_q   <= en_n;
      done_q <= done_n;
      busy_q <= busy_n;
      data_q <= data_n;
      cnt_q  <= cnt_n;
    end
  end

  // Request arbitration (load > stop > step > burst > run), pacing and burst count
  always_comb begin
    st_n   = st_q;
    pcnt_n = pcnt_q;
    rem_n  = rem_q;
    load_n = 1'b0;
    en_n   = 1'b0;
    done_n = 1'b0;
    data_n = data_q;
    cnt_n  = cnt_q;
    if (bus.load_req) begin
      st_n   = IDLE;
      load_n = 1'b1;
      data_n = bus.seed;
      cnt_n  = '0;
      pcnt_n = '0;
    end else if (bus.stop_req && (st_q != IDLE)) begin
      st_n   = IDLE;
      pcnt_n = '0;
    end else begin
      case (st_q)
        IDLE: begin
          pcnt_n = '0;
          // The request cycle itself counts as prescaler cycle 0, so a
          // div=0 entry steps immediately and otherwise resumes at 1.
          if (bus.stop_req) begin
            st_n = IDLE;
          end else if (bus.step_req) begin
            en_n = 1'b1;
          end else if (bus.burst_req) begin
            if (bus.burst_len == '0) begin
              done_n = 1'b1;
            end else begin
              st_n = BURST;
              if (bus.div == '0) begin
                en_n  = 1'b1;
                rem_n = bus.burst_len - 8'd1;
              end else begin
                rem_n  = bus.burst_len;
                pcnt_n = DIV_W'(1);
              end
            end
          end else if (bus.run_req) begin
            st_n = RUN;
            if (bus.div == '0) en_n = 1'b1;
            else               pcnt_n = DIV_W'(1);
          end
        end
        RUN: begin
          if (tick) begin
            en_n   = 1'b1;
            pcnt_n = '0;
          end else begin
            pcnt_n = pcnt_q + DIV_W'(1);
          end
        end
        BURST: begin
          // rem reaching zero means the final step is already out; finish here
          if (rem_q == '0) begin
            st_n   = IDLE;
            done_n = 1'b1;
            pcnt_n = '0;
          end else if (tick) begin
            en_n   = 1'b1;
            rem_n  = rem_q - 8'd1;
            pcnt_n = '0;
          end else begin
            pcnt_n = pcnt_q + DIV_W'(1);
          end
        end
        default: begin
          st_n   = IDLE;
          pcnt_n = '0;
        end
      endcase
    end
    if (en_n) cnt_n = cnt_q + CNT_W'(1);
    busy_n = (st_n != IDLE);
  end

  assign bus.lfsr_load = load_q;
  assign bus.lfsr_data = data_q;
  assign bus.lfsr_en   = en_q;
  assign bus.state     = st_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Scoreboard bench for lfsr_step_ctrl: stimulus tasks predict strobe events
// (cycle, kind, data, step count) from the request rules; a monitor pops and
// compares every lfsr_load / lfsr_en / done the DUT presents.
module tb_lfsr_step_ctrl;
  localparam int WIDTH = 8;
  localparam int DIV_W = 24;
  localparam int CNT_W = 16;
  localparam int EV_LOAD = 0;
  localparam int EV_EN   = 1;
  localparam int EV_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_step_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  lfsr_step_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
    logic [15:0] cnt;
  } ev_t;

  ev_t         q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  int          cyc = 0;
  int          last_ev = 0;
  int unsigned m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input int k, input logic [7:0] d);
    ev_t e;
    if (k == EV_EN)   m_cnt = (m_cnt + 1) & 32'hFFFF;
    if (k == EV_LOAD) m_cnt = 0;
    e.cyc = c; e.kind = k; e.data = d; e.cnt = m_cnt[15:0];
    q.push_back(e);
    if (c > last_ev) last_ev = c;
  endfunction

  function automatic void mark(input int c);
    if (c > last_ev) last_ev = c;
  endfunction

  // Monitor: every strobe must match the oldest predicted event
  always @(negedge clk) begin
    if (mon_on) begin
      int k, n;
      ev_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event: got none at cycle %0d expected kind %0d at cycle %0d",
                 cyc, e.kind, e.cyc);
      end
      n = int'(bus.lfsr_load) + int'(bus.lfsr_en) + int'(bus.done);
      k = bus.lfsr_load ? EV_LOAD : bus.lfsr_en ? EV_EN : bus.done ? EV_DONE : -1;
      if (n > 1) begin
        checks++; errors++;
        $display("FAIL strobe_overlap: got load=%0b en=%0b done=%0b expected at most one (cycle %0d)",
                 bus.lfsr_load, bus.lfsr_en, bus.done, cyc);
      end
      if (k >= 0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.kind != k || bus.step_cnt !== e.cnt ||
              (k == EV_LOAD && bus.lfsr_data !== e.data)) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d data %0h cnt %0h expected kind %0d cyc %0d data %0h cnt %0h",
                     k, cyc, bus.lfsr_data, bus.step_cnt, e.kind, e.cyc, e.data, e.cnt);
          end
        end
      end
    end
  end

  task automatic tick1;
    @(posedge clk); #1;
  endtask

  task automatic drain;
    while (cyc <= last_ev) tick1;
    tick1;
  endtask

  task automatic pulse(input bit i_load, input bit i_stop, input bit i_step, input bit i_burst,
                       input bit i_run, input logic [7:0] sd, input logic [7:0] bl, output int t);
    bus.load_req = i_load; bus.stop_req = i_stop; bus.step_req = i_step;
    bus.burst_req = i_burst; bus.run_req = i_run;
    bus.seed = sd; bus.burst_len = bl;
    t = cyc;
    tick1;
    bus.load_req = 0; bus.stop_req = 0; bus.step_req = 0;
    bus.burst_req = 0; bus.run_req = 0;
  endtask

  task automatic do_load(input logic [7:0] sd);
    int t;
    pulse(1, 0, 0, 0, 0, sd, 8'd0, t);
    push_ev(t + 1, EV_LOAD, sd);
    chk("load_data", bus.lfsr_data, sd);
    chk("load_busy", bus.busy, 0);
    drain;
  endtask

  task automatic do_step;
    int t;
    pulse(0, 0, 1, 0, 0, 8'd0, 8'd0, t);
    push_ev(t + 1, EV_EN, 0);
    chk("step_busy", bus.busy, 0);
    drain;
  endtask

  // ab = cycles after the request at which stop (or load) aborts; 0 = run to completion
  task automatic do_burst(input int len, input int d, input int ab, input bit ab_ld,
                          input bit ab_extra, input logic [7:0] sd);
    int t, ta, fin, tt;
    bus.div = DIV_W'(d);
    pulse(0, 0, 0, 1, 0, 8'd0, len[7:0], t);
    if (len == 0) begin
      push_ev(t + 1, EV_DONE, 0);
      chk("zero_burst_busy", bus.busy, 0);
      chk("zero_burst_state", bus.state, 0);
      drain;
      return;
    end
    fin = t + (d + 1) * len;
    ta  = (ab == 0) ? fin + 1 : t + ab;
    for (int k = 1; k <= len; k++) begin
      tt = t + (d + 1) * k;
      if (ab == 0 || tt <= ta) push_ev(tt, EV_EN, 0);
    end
    if (ab == 0) push_ev(fin + 1, EV_DONE, 0);
    while (cyc < ta) begin
      chk("burst_busy", bus.busy, 1);
      chk("burst_state", bus.state, 2);
      tick1;
    end
    if (ab != 0) begin
      pulse(ab_ld, 1, ab_extra, ab_extra, ab_extra, sd, 8'd3, tt);
      if (ab_ld) push_ev(ta + 1, EV_LOAD, sd);
      mark(ta + 1);
    end
    chk("burst_end_busy", bus.busy, 0);
    chk("burst_end_state", bus.state, 0);
    drain;
  endtask

  // Free run stopped (or reloaded) dur cycles after the request
  task automatic do_run(input int d, input int dur, input bit ab_ld, input logic [7:0] sd);
    int t, ts, tt;
    bus.div = DIV_W'(d);
    pulse(0, 0, 0, 0, 1, 8'd0, 8'd0, t);
    ts = t + dur;
    for (int k = 1; t + (d + 1) * k <= ts; k++) push_ev(t + (d + 1) * k, EV_EN, 0);
    while (cyc < ts) begin
      chk("run_busy", bus.busy, 1);
      chk("run_state", bus.state, 1);
      tick1;
    end
    pulse(ab_ld, !ab_ld, 0, 0, 0, sd, 8'd0, tt);
    if (ab_ld) push_ev(ts + 1, EV_LOAD, sd);
    mark(ts + 1);
    chk("run_end_busy", bus.busy, 0);
    chk("run_end_state", bus.state, 0);
    drain;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_load"}, bus.lfsr_load, 0);
    chk({nm, "_en"}, bus.lfsr_en, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_cnt"}, bus.step_cnt, 0);
    chk({nm, "_data"}, bus.lfsr_data, 0);
    chk({nm, "_state"}, bus.state, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tt, len, d, ab;
    bus.seed = 0; bus.load_req = 0; bus.step_req = 0; bus.burst_req = 0;
    bus.burst_len = 0; bus.run_req = 0; bus.stop_req = 0; bus.div = 0;
    tick1; tick1;
    chk_all_zero("reset");
    rst = 0;
    mon_on = 1;
    tick1;

    // Seed load, then single steps
    do_load(8'hA5);
    repeat (3) do_step;
    chk("three_steps_cnt", bus.step_cnt, 3);

    // Paced burst, then free run
    do_burst(5, 3, 0, 0, 0, 8'd0);
    chk("burst_cnt", bus.step_cnt, 8);
    do_run(0, 9, 0, 8'd0);
    chk("run_cnt", bus.step_cnt, 17);

    // Mid-burst load+stop+step: only the load acts, no done
    do_burst(5, 3, 9, 1, 1, 8'h3C);
    chk("abort_cnt", bus.step_cnt, 0);

    // Empty burst
    do_burst(0, 2, 0, 0, 0, 8'd0);

    // step outranks burst and run in IDLE
    pulse(0, 0, 1, 1, 1, 8'd0, 8'd4, t);
    push_ev(t + 1, EV_EN, 0);
    chk("prio_state", bus.state, 0);
    drain;
    // stop outranks step in IDLE: nothing happens
    pulse(0, 1, 1, 0, 0, 8'd0, 8'd0, t);
    mark(t + 2);
    chk("stop_idle_state", bus.state, 0);
    drain;

    // Lowering div below the running count ticks on the next cycle
    bus.div = DIV_W'(7);
    pulse(0, 0, 0, 0, 1, 8'd0, 8'd0, t);
    push_ev(t + 4, EV_EN, 0);
    push_ev(t + 6, EV_EN, 0);
    push_ev(t + 8, EV_EN, 0);
    tick1; tick1;
    bus.div = DIV_W'(1);
    while (cyc < t + 9) tick1;
    pulse(0, 1, 0, 0, 0, 8'd0, 8'd0, tt);
    mark(t + 10);
    drain;

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: do_load(8'($urandom));
        1: do_step;
        2: begin
          len = $urandom_range(0, 6);
          d   = $urandom_range(0, 3);
          ab  = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(1, (d + 1) * len) : 0;
          do_burst(len, d, ab, 1'($urandom), 1'($urandom), 8'($urandom));
        end
        3: do_run($urandom_range(0, 3), $urandom_range(1, 20), 1'($urandom), 8'($urandom));
        default: begin
          bus.div = DIV_W'($urandom_range(0, 3));
          pulse(0, 0, 1, 1'($urandom), 1'($urandom), 8'd0, 8'd2, t);
          push_ev(t + 1, EV_EN, 0);
          drain;
        end
      endcase
    end

    // step_cnt wrap FFFF -> 0000
    do_load(8'h81);
    do_run(0, 65535, 0, 8'd0);
    chk("cnt_ffff", bus.step_cnt, 16'hFFFF);
    do_step;
    chk("cnt_wrap", bus.step_cnt, 0);

    // Asynchronous reset mid-run
    mon_on = 0;
    bus.div = 0;
    pulse(0, 0, 0, 0, 1, 8'd0, 8'd0, t);
    tick1; tick1;
    #2 rst = 1;
    #1 chk_all_zero("async_reset");
    tick1;
    rst = 0;
    m_cnt = 0;
    q.delete();
    mon_on = 1;
    do_step;
    chk("post_reset_cnt", bus.step_cnt, 1);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
